// File: rtl/game_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
// Cell encoding, FSM states and the winning-line table.
package game_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    WIN   = 2'd2,
    DRAW  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    X     = 2'd1,
    O     = 2'd2
  } cell_e;

  localparam logic [3:0] NO_POS = 4'hF;

  localparam logic [3:0] WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] other_side(input logic [1:0] t);
    return (t == X) ? O : X;
  endfunction

endpackage

// File: rtl/game_controller_edge_detect.sv
// Rising-edge detector for one debounced button.
// An edge is only reported once the button has been seen low after reset.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_q, btn_d;
  logic armed_q, armed_d;

  always_comb begin
    btn_d   = btn;
    armed_d = armed_q | ~btn;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      btn_q   <= btn_d;
      armed_q <= armed_d;
    end
  end

  assign rise = btn & ~btn_q & armed_q;

endmodule

// File: rtl/game_controller.sv
// Tic-tac-toe game controller: board, cursor, turn timer and win scan.
// The win scan walks the line table one line per cycle after each placement.
module game_controller
  import game_pkg::*;
#(
  parameter int TURN_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_move,
  input  logic       btn_place,
  input  logic       btn_restart,
  input  logic       frame_tick,
  input  logic [3:0] player_address,
  output logic [1:0] player,
  output logic [3:0] sel_position,
  output logic [3:0] pos1,
  output logic [3:0] pos2,
  output logic [3:0] pos3,
  output logic [1:0] turn,
  output logic       game_over
);

  localparam int TW =
    (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(TURN_FRAMES - 1);

  logic rise_move, rise_place, rise_restart;

  edge_detect u_ed_move (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_move),
    .rise (rise_move)
  );

  edge_detect u_ed_place (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_place),
    .rise (rise_place)
  );

  edge_detect u_ed_restart (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_restart),
    .rise (rise_restart)
  );

  state_e          state_q, state_d;
  logic [8:0][1:0] board_q, board_d;
  logic [3:0]      cursor_q, cursor_d;
  logic [1:0]      turn_q, turn_d;
  logic [3:0]      pos1_q, pos1_d;
  logic [3:0]      pos2_q, pos2_d;
  logic [3:0]      pos3_q, pos3_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      line_q, line_d;
  logic [1:0]      player_q, player_d;
  logic            over_q, over_d;

  logic [3:0] ca, cb, cc;
  logic       hit, full, placed;

  always_comb begin
    ca  = WIN_LINES[line_q][0];
    cb  = WIN_LINES[line_q][1];
    cc  = WIN_LINES[line_q][2];
    hit = (board_q[ca] == turn_q) &&
          (board_q[cb] == turn_q) &&
          (board_q[cc] == turn_q);
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (board_q[i] == EMPTY) full = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    cursor_d = cursor_q;
    turn_d   = turn_q;
    pos1_d   = pos1_q;
    pos2_d   = pos2_q;
    pos3_d   = pos3_q;
    timer_d  = timer_q;
    line_d   = line_q;
    placed   = 1'b0;

    if (rise_restart) begin
      state_d  = PLAY;
      board_d  = '0;
      cursor_d = 4'd0;
      turn_d   = X;
      pos1_d   = NO_POS;
      pos2_d   = NO_POS;
      pos3_d   = NO_POS;
      timer_d  = '0;
      line_d   = 3'd0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (rise_place) begin
            if (board_q[cursor_q] == EMPTY) begin
              board_d[cursor_q] = turn_q;
              timer_d = '0;
              line_d  = 3'd0;
              state_d = CHECK;
              placed  = 1'b1;
            end
          end else if (rise_move) begin
            cursor_d = (cursor_q == 4'd8) ?
                       4'd0 : cursor_q + 4'd1;
          end
          // a successful placement swallows a same-cycle timeout
          if (!placed && frame_tick) begin
            if (timer_q == T_LAST) begin
              turn_d  = other_side(turn_q);
              timer_d = '0;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        CHECK: begin
          if (hit) begin
            pos1_d  = ca;
            pos2_d  = cb;
            pos3_d  = cc;
            state_d = WIN;
          end else if (line_q == 3'd7) begin
            if (full) begin
              state_d = DRAW;
            end else begin
              turn_d  = other_side(turn_q);
              timer_d = '0;
              state_d = PLAY;
            end
          end else begin
            line_d = line_q + 3'd1;
          end
        end
        WIN, DRAW: ;
        default: state_d = PLAY;
      endcase
    end

    player_d = (player_address > 4'd8) ?
               2'd0 : board_q[player_address];
    over_d   = (state_d == WIN) || (state_d == DRAW);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= PLAY;
      board_q  <= '0;
      cursor_q <= 4'd0;
      turn_q   <= X;
      pos1_q   <= NO_POS;
      pos2_q   <= NO_POS;
      pos3_q   <= NO_POS;
      timer_q  <= '0;
      line_q   <= 3'd0;
      player_q <= 2'd0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      cursor_q <= cursor_d;
      turn_q   <= turn_d;
      pos1_q   <= pos1_d;
      pos2_q   <= pos2_d;
      pos3_q   <= pos3_d;
      timer_q  <= timer_d;
      line_q   <= line_d;
      player_q <= player_d;
      over_q   <= over_d;
    end
  end

  assign player       = player_q;
  assign sel_position = cursor_q;
  assign pos1         = pos1_q;
  assign pos2         = pos2_q;
  assign pos3         = pos3_q;
  assign turn         = turn_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller (TURN_FRAMES = 4).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_game_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_move, btn_place, btn_restart;
  logic       frame_tick;
  logic [3:0] player_address;
  logic [1:0] player;
  logic [3:0] sel_position, pos1, pos2, pos3;
  logic [1:0] turn;
  logic       game_over;

  int tests_run    = 0;
  int tests_failed = 0;
  int cur          = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];

  game_controller #(.TURN_FRAMES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_move       (btn_move),
    .btn_place      (btn_place),
    .btn_restart    (btn_restart),
    .frame_tick     (frame_tick),
    .player_address (player_address),
    .player         (player),
    .sel_position   (sel_position),
    .pos1           (pos1),
    .pos2           (pos2),
    .pos3           (pos3),
    .turn           (turn),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag,
                          input int obs,
                          input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic expect_now(input string tag,
                            input int obs,
                            input int exp);
    sb_push(tag, exp);
    sb_pop(obs);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic mv, input logic pl,
                       input logic rs, input logic tk);
    btn_move    = mv;
    btn_place   = pl;
    btn_restart = rs;
    frame_tick  = tk;
    step();
    btn_move    = 1'b0;
    btn_place   = 1'b0;
    btn_restart = 1'b0;
    frame_tick  = 1'b0;
    step();
  endtask

  task automatic goto_cell(input int t);
    int n;
    n = (t - cur + 9) % 9;
    repeat (n) press(1, 0, 0, 0);
    cur = t;
  endtask

  task automatic settle();
    repeat (8) step();
  endtask

  task automatic place_at(input int t);
    goto_cell(t);
    press(0, 1, 0, 0);
    settle();
  endtask

  task automatic read_cell(input int a, input int exp);
    player_address = a[3:0];
    sb_push($sformatf("player[%0d]", a), exp);
    step();
    sb_pop(player);
  endtask

  task automatic check_idle(input string tag);
    expect_now({tag, "_sel"}, sel_position, 0);
    expect_now({tag, "_turn"}, turn, 1);
    expect_now({tag, "_over"}, game_over, 0);
    expect_now({tag, "_pos1"}, pos1, 15);
    expect_now({tag, "_pos2"}, pos2, 15);
    expect_now({tag, "_pos3"}, pos3, 15);
  endtask

  initial begin
    int cyc;
    int brd[9];
    rst            = 1'b0;
    btn_move       = 1'b0;
    btn_place      = 1'b0;
    btn_restart    = 1'b0;
    frame_tick     = 1'b0;
    player_address = 4'd0;
    @(negedge clk);
    step();
    step();
    check_idle("reset");
    expect_now("reset_player", player, 0);
    rst = 1'b1;
    step();

    for (int i = 1; i <= 9; i++) begin
      press(1, 0, 0, 0);
      expect_now($sformatf("move%0d", i),
                 sel_position, i % 9);
    end
    cur = 0;
    for (int a = 0; a < 16; a++) read_cell(a, 0);

    // X wins the top row
    place_at(0);
    place_at(3);
    place_at(1);
    place_at(4);
    goto_cell(2);
    press(0, 1, 0, 0);
    cyc = 0;
    while (!game_over && cyc < 8) begin
      step();
      cyc++;
    end
    expect_now("win_over", game_over, 1);
    expect_now("win_pos1", pos1, 0);
    expect_now("win_pos2", pos2, 1);
    expect_now("win_pos3", pos3, 2);
    expect_now("win_turn", turn, 1);
    brd = '{1, 1, 1, 2, 2, 0, 0, 0, 0};
    for (int a = 0; a < 9; a++) read_cell(a, brd[a]);
    press(1, 0, 0, 0);
    press(0, 0, 0, 1);
    expect_now("win_frozen_sel", sel_position, 2);
    expect_now("win_frozen_pos1", pos1, 0);

    press(0, 0, 1, 0);
    cur = 0;
    check_idle("restart1");
    for (int a = 0; a < 9; a++) read_cell(a, 0);

    // occupied placement, then move+place together
    place_at(0);
    expect_now("x0_turn", turn, 2);
    press(0, 1, 0, 0);
    settle();
    expect_now("occ_turn", turn, 2);
    read_cell(0, 1);
    goto_cell(1);
    press(1, 1, 0, 0);
    expect_now("mvpl_sel", sel_position, 1);
    settle();
    expect_now("mvpl_turn", turn, 1);
    read_cell(1, 2);

    // turn timer
    press(0, 0, 1, 0);
    cur = 0;
    repeat (3) press(0, 0, 0, 1);
    expect_now("tick3_turn", turn, 1);
    press(0, 0, 0, 1);
    expect_now("tick4_turn", turn, 2);
    for (int a = 0; a < 9; a++) read_cell(a, 0);
    repeat (3) press(0, 0, 0, 1);
    expect_now("tick7_turn", turn, 2);
    press(0, 1, 0, 1);
    expect_now("pltick_mid", turn, 2);
    settle();
    expect_now("pltick_turn", turn, 1);
    read_cell(0, 2);
    press(0, 0, 0, 1);
    expect_now("post_tick_turn", turn, 1);

    // draw
    press(0, 0, 1, 0);
    cur = 0;
    place_at(0);
    place_at(1);
    place_at(2);
    place_at(4);
    place_at(3);
    place_at(5);
    place_at(7);
    place_at(6);
    place_at(8);
    expect_now("draw_over", game_over, 1);
    expect_now("draw_pos1", pos1, 15);
    expect_now("draw_pos2", pos2, 15);
    expect_now("draw_pos3", pos3, 15);
    brd = '{1, 2, 1, 1, 2, 2, 2, 1, 1};
    for (int a = 0; a < 9; a++) read_cell(a, brd[a]);
    press(0, 0, 1, 0);
    cur = 0;
    check_idle("restart2");
    for (int a = 0; a < 9; a++) read_cell(a, 0);

    // reset in the middle of the scan
    place_at(1);
    goto_cell(0);
    btn_place = 1'b1;
    step();
    btn_place = 1'b0;
    step();
    rst = 1'b0;
    btn_move = 1'b1;
    step();
    check_idle("midrst");
    expect_now("midrst_player", player, 0);
    rst = 1'b1;
    step();
    step();
    expect_now("held_btn_sel", sel_position, 0);
    btn_move = 1'b0;
    settle();
    expect_now("midrst_over", game_over, 0);
    expect_now("midrst_turn", turn, 1);
    read_cell(0, 0);
    read_cell(1, 0);
    cur = 0;
    press(1, 0, 0, 0);
    expect_now("rearm_sel", sel_position, 1);

    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule
